// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one bus port between instruction fetch (I) and load/store (D),
// one transaction at a time, with D priority, I starvation guard and a bus timeout.
module mem_bus_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ack,
    output logic            i_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_sel,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ack,
    output logic            d_err,
    output logic            m_cyc,
    output logic            m_stb,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_sel,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_ack,
    input  logic            m_err,
    output logic            busy
);

    localparam int SW = DW / 8;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t          state_q, state_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [CW-1:0]   starve_q, starve_d;

    logic tmo_hit, bus_ok, bus_fail, done, starved;

    assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));
    assign bus_ok   = m_ack && !m_err;
    // A real completion in the timeout cycle takes precedence over the abort.
    assign bus_fail = m_err || (tmo_hit && !m_ack);
    assign done     = m_ack || m_err || tmo_hit;
    assign starved  = i_req && (starve_q == CW'(STARVE_MAX));

    assign i_ack   = (state_q == GNT_I) && bus_ok;
    assign i_err   = (state_q == GNT_I) && bus_fail;
    assign d_ack   = (state_q == GNT_D) && bus_ok;
    assign d_err   = (state_q == GNT_D) && bus_fail;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    assign m_cyc   = cyc_q;
    assign m_stb   = cyc_q;
    assign m_we    = we_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign m_sel   = sel_q;
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        tmo_d    = tmo_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (!i_req) begin
                    starve_d = '0;
                end
                if (d_req && !starved) begin
                    state_d = GNT_D;
                    cyc_d   = 1'b1;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    sel_d   = d_sel;
                    tmo_d   = '0;
                    if (i_req) begin
                        starve_d = starve_q + CW'(1);
                    end
                end else if (i_req) begin
                    state_d  = GNT_I;
                    cyc_d    = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = i_addr;
                    wdata_d  = '0;
                    sel_d    = '1;
                    tmo_d    = '0;
                    starve_d = '0;
                end
            end
            GNT_I, GNT_D: begin
                if (done) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_q    <= '0;
            tmo_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            tmo_q    <= tmo_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table for single transactions, directed sequences
// for starvation, timeout and mid-transaction reset.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ack, i_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_sel = '0;
    logic [31:0] d_rdata;
    logic        d_ack, d_err;
    logic        m_cyc, m_stb, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_sel;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;
    logic        m_err = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(255), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_sel(m_sel), .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_sel;
        logic        m_ack;
        logic        m_err;
        logic [31:0] m_rdata;
        logic        e_cyc;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_sel;
        logic        e_iack;
        logic        e_ierr;
        logic        e_dack;
        logic        e_derr;
        logic        e_busy;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input string nm);
        int w;
        w = 0;
        while (!m_cyc && w < 10) begin
            tick();
            w++;
        end
        chk({nm, " grant within bound"}, {31'd0, m_cyc}, 32'd1);
    endtask

    localparam logic [31:0] I_ST = 32'hA00;
    localparam logic [31:0] D_ST = 32'hD00;

    initial begin
        int grant_d [6];
        int errcyc;
        int early;

        //                 i_req i_addr      d_req d_we  d_addr      d_wdata       d_sel  ack   err   rdata
        //                 e_cyc e_we  e_addr      e_wdata       e_sel  iack  ierr  dack  derr  busy
        vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,
                     1'b1, 1'b0, 32'h100, 32'h0,        4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEEF,
                     1'b1, 1'b0, 32'h100, 32'h0,        4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 32'h200, 1'b1, 1'b1, 32'h300, 32'h12345678, 4'h3, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 32'h200, 1'b1, 1'b1, 32'h300, 32'h12345678, 4'h3, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b1, 32'h300, 32'h12345678, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 32'hA5A5A5A5,
                     1'b1, 1'b0, 32'h200, 32'h0,        4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'h400, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b1, 32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 32'h400, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b1, 32'h0,
                     1'b1, 1'b0, 32'h400, 32'h0,        4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h500, 32'h0,        4'hF, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h500, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0,
                     1'b1, 1'b0, 32'h500, 32'h0,        4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // reset state
        tick();
        chk("rst m_cyc", {31'd0, m_cyc}, 32'd0);
        chk("rst m_stb", {31'd0, m_stb}, 32'd0);
        chk("rst m_we", {31'd0, m_we}, 32'd0);
        chk("rst m_addr", m_addr, 32'h0);
        chk("rst m_wdata", m_wdata, 32'h0);
        chk("rst m_sel", {28'd0, m_sel}, 32'h0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst strobes", {28'd0, i_ack, i_err, d_ack, d_err}, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            i_req   = vecs[i].i_req;
            i_addr  = vecs[i].i_addr;
            d_req   = vecs[i].d_req;
            d_we    = vecs[i].d_we;
            d_addr  = vecs[i].d_addr;
            d_wdata = vecs[i].d_wdata;
            d_sel   = vecs[i].d_sel;
            m_ack   = vecs[i].m_ack;
            m_err   = vecs[i].m_err;
            m_rdata = vecs[i].m_rdata;
            #1;
            chk($sformatf("v%0d m_cyc", i), {31'd0, m_cyc}, {31'd0, vecs[i].e_cyc});
            chk($sformatf("v%0d m_stb", i), {31'd0, m_stb}, {31'd0, vecs[i].e_cyc});
            chk($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
            chk($sformatf("v%0d strobes", i), {28'd0, i_ack, i_err, d_ack, d_err},
                {28'd0, vecs[i].e_iack, vecs[i].e_ierr, vecs[i].e_dack, vecs[i].e_derr});
            chk($sformatf("v%0d i_rdata", i), i_rdata, vecs[i].m_rdata);
            chk($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].m_rdata);
            if (vecs[i].e_cyc) begin
                chk($sformatf("v%0d m_we", i), {31'd0, m_we}, {31'd0, vecs[i].e_we});
                chk($sformatf("v%0d m_addr", i), m_addr, vecs[i].e_addr);
                chk($sformatf("v%0d m_wdata", i), m_wdata, vecs[i].e_wdata);
                chk($sformatf("v%0d m_sel", i), {28'd0, m_sel}, {28'd0, vecs[i].e_sel});
            end
            tick();
        end

        // requester drops req mid-grant: ack still delivered
        i_req = 1'b1; i_addr = 32'h800;
        tick();
        i_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hCAFEF00D;
        #1;
        chk("drop i_ack", {31'd0, i_ack}, 32'd1);
        chk("drop i_rdata", i_rdata, 32'hCAFEF00D);
        tick();
        m_ack = 1'b0;
        chk("drop idle busy", {31'd0, busy}, 32'd0);
        tick();

        // starvation: I held, D reissued six times
        i_req = 1'b1; i_addr = I_ST;
        d_req = 1'b1; d_addr = D_ST; d_we = 1'b0; d_sel = 4'hF;
        for (int g = 0; g < 6; g++) begin
            wait_cyc($sformatf("starve %0d", g));
            grant_d[g] = (m_addr == D_ST) ? 1 : 0;
            m_ack = 1'b1;
            #1;
            chk($sformatf("starve %0d ack", g), {30'd0, i_ack, d_ack},
                (grant_d[g] == 1) ? 32'd1 : 32'd2);
            tick();
            m_ack = 1'b0;
        end
        chk("starve grants", {26'd0, grant_d[0][0], grant_d[1][0], grant_d[2][0],
            grant_d[3][0], grant_d[4][0], grant_d[5][0]}, 32'b111101);
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // timeout with no bus response
        d_req = 1'b1; d_addr = 32'h600; d_we = 1'b0;
        tick();
        errcyc = 0;
        for (int n = 1; n <= 300; n++) begin
            if (d_err) begin
                errcyc = n;
                break;
            end
            tick();
        end
        chk("tmo err cycle", errcyc, 32'd255);
        chk("tmo no ack", {31'd0, d_ack}, 32'd0);
        d_req = 1'b0;
        tick();
        chk("tmo m_cyc low", {31'd0, m_cyc}, 32'd0);
        chk("tmo busy low", {31'd0, busy}, 32'd0);
        tick();

        // m_ack in the timeout cycle wins
        d_req = 1'b1;
        tick();
        early = 0;
        for (int n = 1; n < 255; n++) begin
            if (d_err) early++;
            tick();
        end
        chk("tmo2 early err", early, 32'd0);
        m_ack = 1'b1;
        #1;
        chk("tmo2 ack wins", {30'd0, d_ack, d_err}, 32'b10);
        d_req = 1'b0;
        tick();
        m_ack = 1'b0;
        chk("tmo2 m_cyc low", {31'd0, m_cyc}, 32'd0);
        tick();

        // async reset mid GNT_D
        d_req = 1'b1; d_addr = 32'h700; d_we = 1'b1; d_wdata = 32'h55; d_sel = 4'h1;
        tick();
        chk("rstmid granted", {31'd0, m_cyc}, 32'd1);
        m_ack = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid m_cyc", {30'd0, m_cyc, m_stb}, 32'd0);
        chk("rstmid no ack", {30'd0, d_ack, d_err}, 32'd0);
        chk("rstmid busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b0; m_ack = 1'b0;
        wait_cyc("rstmid regrant");
        chk("rstmid regrant addr", m_addr, 32'h700);
        chk("rstmid regrant we", {31'd0, m_we}, 32'd1);
        m_ack = 1'b1;
        #1;
        chk("rstmid regrant ack", {31'd0, d_ack}, 32'd1);
        d_req = 1'b0;
        tick();
        m_ack = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
